exit_uart_reporter: RTL and testbench

- Consumer end of the core's exit/exitcode status interface.
- Watches for the core's exit event, captures the 32-bit exit code, and transmits it once as an ASCII line over an 8N1 UART TX pin.
- Sits in the top level beside the processor and LED mapping, so results can be read on a host terminal instead of only 3 LED bits.

---
 rtl/exit_report_pkg.sv | 25 ++
 rtl/exit_uart_reporter_if.sv | 12 +
 rtl/uart_tx_byte.sv | 65 ++++++
 rtl/exit_uart_reporter.sv | 147 ++++++++++++++
 tb/tb_exit_uart_reporter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exit_report_pkg.sv
// Shared types and constants for the exit-code UART reporter.
// EXIT_REPORT_REPEAT_EN (optional) makes the message repeat after a fixed idle gap.
package exit_report_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StFin,
        StHalt
    } state_e;

    localparam int unsigned MSG_LEN         = 12;
    localparam logic [7:0]  ASCII_CR        = 8'h0D;
    localparam logic [7:0]  ASCII_LF        = 8'h0A;
    localparam int unsigned REPEAT_GAP_LOG2 = 20;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/exit_uart_reporter_if.sv
// Exit/status handshake between the core and the exit-code reporter.
interface exit_uart_reporter_if;

    logic        exit;
    logic [31:0] exitcode;
    logic        busy;
    logic        done;

    modport master (output exit, output exitcode, input busy, input done);
    modport slave  (input exit, input exitcode, output busy, output done);

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done_pulse
);

    localparam logic [15:0] LastBaud = 16'(CLKS_PER_BIT - 1);

    logic        active_q, active_d;
    logic [9:0]  shift_q, shift_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] baud_q, baud_d;
    logic        bit_end;

    assign bit_end    = active_q && (baud_q == LastBaud);
    assign done_pulse = bit_end && (bit_q == 4'd9);
    // Ones shift in behind the frame, so the line idles high with no extra mux.
    assign tx         = shift_q[0];

    always_comb begin
        active_d = active_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        baud_d   = baud_q;
        if (!active_q) begin
            if (start) begin
                active_d = 1'b1;
                shift_d  = {1'b1, data, 1'b0};
                bit_d    = 4'd0;
                baud_d   = 16'd0;
            end
        end else if (bit_end) begin
            baud_d  = 16'd0;
            shift_d = {1'b1, shift_q[9:1]};
            if (bit_q == 4'd9) begin
                active_d = 1'b0;
            end else begin
                bit_d = bit_q + 4'd1;
            end
        end else begin
            baud_d = baud_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            active_q <= 1'b0;
            shift_q  <= '1;
            bit_q    <= 4'd0;
            baud_q   <= 16'd0;
        end else begin
            active_q <= active_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
        end
    end

endmodule

// File: rtl/exit_uart_reporter.sv
// Captures the core exit code on the rising edge of exit and sends "X=hhhhhhhh\r\n" over UART.
// Define EXIT_REPORT_REPEAT_EN to resend the message after every 2^20-cycle idle gap.
module exit_uart_reporter
    import exit_report_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [15:0] MSG_PREFIX   = "X="
) (
    input  logic                  clk,
    input  logic                  resetn,
    exit_uart_reporter_if.slave   rpt,
    output logic                  uart_tx
);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] code_q, code_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        start_q, start_d;
    logic [7:0]  data_q, data_d;
    logic        exit_q;
    logic        trigger;
    logic        byte_done;
    logic [3:0]  nib;
    logic [7:0]  msg_byte;
`ifdef EXIT_REPORT_REPEAT_EN
    logic [REPEAT_GAP_LOG2-1:0] gap_q, gap_d;
`endif

    assign trigger = rpt.exit & ~exit_q & ~done_q & ~busy_q;
    assign rpt.busy = busy_q;
    assign rpt.done = done_q;

    // Byte indices 2..9 walk the code from nibble [31:28] down to [3:0].
    assign nib = 4'(code_q >> {4'd9 - idx_q, 2'b00});

    always_comb begin
        msg_byte = ASCII_LF;
        case (idx_q)
            4'd0:    msg_byte = MSG_PREFIX[15:8];
            4'd1:    msg_byte = MSG_PREFIX[7:0];
            4'd10:   msg_byte = ASCII_CR;
            4'd11:   msg_byte = ASCII_LF;
            default: msg_byte = hex_char(nib);
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        code_d  = code_q;
        busy_d  = busy_q;
        done_d  = done_q;
        start_d = 1'b0;
        data_d  = data_q;
`ifdef EXIT_REPORT_REPEAT_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d = StLoad;
                    busy_d  = 1'b1;
                    code_d  = rpt.exitcode;
                    idx_d   = 4'd0;
                end
            end
            StLoad: begin
                start_d = 1'b1;
                data_d  = msg_byte;
                state_d = StSend;
            end
            StSend: begin
                if (byte_done) begin
                    if (idx_q == 4'(MSG_LEN - 1)) begin
                        state_d = StFin;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StLoad;
                    end
                end
            end
            StFin: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StHalt;
`ifdef EXIT_REPORT_REPEAT_EN
                gap_d   = '0;
`endif
            end
            StHalt: begin
`ifdef EXIT_REPORT_REPEAT_EN
                if (&gap_q) begin
                    code_d  = rpt.exitcode;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = StLoad;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            code_q  <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'd0;
            exit_q  <= 1'b0;
`ifdef EXIT_REPORT_REPEAT_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
            data_q  <= data_d;
            exit_q  <= rpt.exit;
`ifdef EXIT_REPORT_REPEAT_EN
            gap_q   <= gap_d;
`endif
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start_q),
        .data      (data_q),
        .tx        (uart_tx),
        .done_pulse(byte_done)
    );

endmodule

// File: tb/tb_exit_uart_reporter.sv
// Bench for exit_uart_reporter: timing model, UART decoder and directed scenarios.
module tb_exit_uart_reporter;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB + 2;
    localparam int TOTAL = 12 * FRAME + 1;

    logic clk;
    logic resetn;
    logic uart_tx;

    exit_uart_reporter_if rpt_if ();

    exit_uart_reporter #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .rpt    (rpt_if),
        .uart_tx(uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: message text from the code, waveform from its position in time.
    int    cyc     = 0;
    bit    m_armed = 0;
    int    tr      = 0;
    string m_msg   = "";
    bit    exit_prev = 0;
    bit    check_en  = 0;

    function automatic string make_msg(input logic [31:0] c);
        string s;
        s = $sformatf("%h", c);
        s = s.toupper();
        return {"X=", s, "\015\012"};
    endfunction

    function automatic logic exp_busy(input int c);
        return m_armed && ((c - tr) < TOTAL);
    endfunction

    function automatic logic exp_done(input int c);
        return m_armed && ((c - tr) >= TOTAL);
    endfunction

    function automatic logic exp_tx(input int c);
        int t, u, k, r, b;
        byte ch;
        if (!m_armed) return 1'b1;
        t = c - tr;
        if (t < 2) return 1'b1;
        u = t - 2;
        k = u / FRAME;
        r = u % FRAME;
        if (k >= 12 || r >= 10 * CPB) return 1'b1;
        b = r / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        ch = m_msg[k];
        return ch[b-1];
    endfunction

    initial forever begin
        @(posedge clk);
        if (!resetn) begin
            m_armed   = 0;
            exit_prev = 0;
        end else begin
            if (rpt_if.exit && !exit_prev && !exp_busy(cyc) && !exp_done(cyc)) begin
                m_armed = 1;
                tr      = cyc + 1;
                m_msg   = make_msg(rpt_if.exitcode);
            end
            exit_prev = rpt_if.exit;
        end
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            check("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx(cyc)});
            check("busy", {31'd0, rpt_if.busy}, {31'd0, exp_busy(cyc)});
            check("done", {31'd0, rpt_if.done}, {31'd0, exp_done(cyc)});
        end
    end

    // UART receiver sampling mid-bit.
    byte unsigned rx_q[$];
    bit           rx_act = 0;
    int           rx_ph  = 0;
    logic [7:0]   rx_sh  = 8'd0;

    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            rx_act = 0;
        end else if (!rx_act) begin
            if (uart_tx === 1'b0) begin
                rx_act = 1;
                rx_ph  = 0;
            end
        end else begin
            rx_ph++;
            if (rx_ph == 9 * CPB + CPB / 2) begin
                rx_act = 0;
                rx_q.push_back(uart_tx === 1'b1 ? rx_sh : 8'h3F);
            end else if ((rx_ph % CPB) == CPB / 2) begin
                rx_sh = {uart_tx, rx_sh[7:1]};
            end
        end
    end

    task automatic check_msg(input string name, input string exp);
        string got_h;
        string exp_h;
        bit    ok;
        got_h = "";
        exp_h = "";
        ok = (rx_q.size() == exp.len());
        for (int i = 0; i < rx_q.size(); i++) begin
            got_h = {got_h, $sformatf("%02h", rx_q[i])};
            if (i < exp.len() && rx_q[i] != exp[i]) ok = 0;
        end
        for (int i = 0; i < exp.len(); i++) exp_h = {exp_h, $sformatf("%02h", exp[i])};
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got bytes %s, expected %s", name, got_h, exp_h);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Runs until done; k=1 is the first edge after the call.
    task automatic run_msg(output int first_low, output int low_run, output int done_k,
                           output logic busy1);
        first_low = -1;
        low_run   = 0;
        done_k    = -1;
        busy1     = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (k == 1) busy1 = rpt_if.busy;
            if (first_low < 0 && uart_tx == 1'b0) first_low = k;
            if (first_low >= 0 && low_run == k - first_low && uart_tx == 1'b0) low_run++;
            if (rpt_if.done) begin
                done_k = k;
                break;
            end
        end
    endtask

    int   first_low, low_run, done_k, low_cnt, busy_cnt;
    logic busy1;

    initial begin
        resetn          = 1'b0;
        rpt_if.exit     = 1'b0;
        rpt_if.exitcode = 32'd0;
        step();
        check_en = 1;
        step();
        check("reset uart_tx", {31'd0, uart_tx}, 32'd1);
        check("reset busy", {31'd0, rpt_if.busy}, 32'd0);
        check("reset done", {31'd0, rpt_if.done}, 32'd0);

        // Basic message, exit rising around cycle 20.
        resetn = 1'b1;
        repeat (16) step();
        rpt_if.exitcode = 32'h0000002A;
        rpt_if.exit     = 1'b1;
        rx_q.delete();
        run_msg(first_low, low_run, done_k, busy1);
        check("start latency", first_low - 1, 32'd2);
        check("first low run", low_run, 32'd16);
        check("done latency", done_k - 1, 32'd505);
        check_msg("msg 2A", "X=0000002A\015\012");

        // A second exit edge after done is ignored.
        rpt_if.exit = 1'b0;
        repeat (5) step();
        rpt_if.exit = 1'b1;
        rx_q.delete();
        repeat (300) step();
        check("no resend", rx_q.size(), 32'd0);

        // Latched code survives exitcode change and exit drop.
        resetn      = 1'b0;
        rpt_if.exit = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
        step();
        rpt_if.exitcode = 32'hDEADBEEF;
        rpt_if.exit     = 1'b1;
        rx_q.delete();
        repeat (100) step();
        rpt_if.exitcode = 32'd0;
        rpt_if.exit     = 1'b0;
        run_msg(first_low, low_run, done_k, busy1);
        check("deadbeef done", {31'd0, done_k > 0}, 32'd1);
        check_msg("msg DEADBEEF", "X=DEADBEEF\015\012");

        // Exit held high through reset release.
        resetn          = 1'b0;
        rpt_if.exit     = 1'b1;
        rpt_if.exitcode = 32'h0000F00D;
        repeat (3) step();
        rx_q.delete();
        resetn = 1'b1;
        run_msg(first_low, low_run, done_k, busy1);
        check("busy after release", {31'd0, busy1}, 32'd1);
        check("release start", first_low, 32'd3);
        check_msg("msg F00D", "X=0000F00D\015\012");

        // Exit low: line stays idle.
        resetn      = 1'b0;
        rpt_if.exit = 1'b0;
        repeat (2) step();
        resetn   = 1'b1;
        low_cnt  = 0;
        busy_cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (uart_tx !== 1'b1) low_cnt++;
            if (rpt_if.busy !== 1'b0) busy_cnt++;
        end
        check("idle tx low cycles", low_cnt, 32'd0);
        check("idle busy cycles", busy_cnt, 32'd0);

        // Reset during byte 5 data bits, then a fresh message.
        rpt_if.exitcode = 32'h0BADCAFE;
        rpt_if.exit     = 1'b1;
        for (int k = 1; k <= 226; k++) step();
        check("busy before abort", {31'd0, rpt_if.busy}, 32'd1);
        resetn = 1'b0;
        step();
        check("abort uart_tx", {31'd0, uart_tx}, 32'd1);
        check("abort busy", {31'd0, rpt_if.busy}, 32'd0);
        check("abort done", {31'd0, rpt_if.done}, 32'd0);
        step();
        rx_q.delete();
        resetn = 1'b1;
        run_msg(first_low, low_run, done_k, busy1);
        check("refresh done latency", done_k - 1, 32'd505);
        check_msg("msg BADCAFE", "X=0BADCAFE\015\012");
        repeat (50) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
